bf_window_fetch: RTL and testbench

Window-fetch front end for the bilateral-filter datapath. Reads the 256×256 8-bit source image in raster order through the image-memory address/data port and keeps K−1 line buffers. Emits one K-pixel vertical column per accepted pixel to the downstream filter core, using a valid/ready handshake. The filter core builds its K×K window from consecutive columns.

---
 rtl/bf_window_fetch_if.sv | 25 ++
 rtl/bf_window_fetch.sv | 174 +++++++++++++++++
 tb/tb_bf_window_fetch.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/bf_window_fetch_if.sv
// Image-memory read port and column output port of the window-fetch front end.
interface bf_window_fetch_if #(
  parameter int K  = 5,
  parameter int DW = 8
);
  logic            in_valid;
  logic [15:0]     in_addr;
  logic [DW-1:0]   in_data;
  logic            col_valid;
  logic            col_ready;
  logic [K*DW-1:0] col_data;
  logic [7:0]      col_x;
  logic [7:0]      col_y;
  logic            fetch_done;

  modport master (
    input  in_valid, in_data, col_ready,
    output in_addr, col_valid, col_data, col_x, col_y, fetch_done
  );

  modport slave (
    output in_valid, in_data, col_ready,
    input  in_addr, col_valid, col_data, col_x, col_y, fetch_done
  );
endinterface

// File: rtl/bf_window_fetch.sv
// Window-fetch front end: raster reads of a 256x256 image through K-1 line
// buffers, emitting one K-pixel vertical column per captured pixel.
module bf_window_fetch #(
  parameter int K  = 5,
  parameter int DW = 8
) (
  input logic               clk,
  input logic               rst,
  bf_window_fetch_if.master bus
);
  localparam int NLB  = K - 1;
  localparam int HALF = (K - 1) / 2;
  localparam int CW   = K * DW;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;
  state_t state_reg, state_next;

  logic [16:0]   cnt_reg;
  logic          pend_reg;
  logic [7:0]    cap_x_reg;
  logic [7:0]    cap_y_reg;

  logic [DW-1:0] lb_rd [NLB];
  logic [CW-1:0] new_data;
  logic [7:0]    new_y;
  logic          col_new;

  logic          out_valid_reg;
  logic [CW-1:0] out_data_reg;
  logic [7:0]    out_x_reg;
  logic [7:0]    out_y_reg;
  logic          skid_valid_reg;
  logic [CW-1:0] skid_data_reg;
  logic [7:0]    skid_x_reg;
  logic [7:0]    skid_y_reg;

  logic          accept;
  logic          load_slot;
  logic          skid_full_next;
  logic          issue;
  logic          last_col;

  assign accept    = out_valid_reg && bus.col_ready;
  assign load_slot = accept || !out_valid_reg;
  assign col_new   = pend_reg && (cap_y_reg >= 8'(K - 1));
  assign new_y     = cap_y_reg - 8'(HALF);
  assign last_col  = (out_x_reg == 8'd255) && (out_y_reg == 8'(255 - HALF));

  // An issue now returns next cycle; only issue if the skid will still be
  // free then, so a stalled output can absorb at most the one pixel in flight.
  assign skid_full_next = load_slot ? (skid_valid_reg && col_new)
                                    : (skid_valid_reg || col_new);
  assign issue = bus.in_valid && !skid_full_next && !cnt_reg[16]
                 && (state_reg != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      pend_reg  <= 1'b0;
      cap_x_reg <= '0;
      cap_y_reg <= '0;
    end else begin
      pend_reg <= issue;
      if (issue) begin
        cnt_reg   <= cnt_reg + 17'd1;
        cap_x_reg <= cnt_reg[7:0];
        cap_y_reg <= cnt_reg[15:8];
      end
    end
  end

  // Line buffer j holds row y-(K-1)+j. Each is read at issue time (registered
  // read) and rewritten at capture with the next-younger row, shifting rows down.
  generate
    for (genvar gi = 0; gi < NLB; gi++) begin : g_lb
      logic [DW-1:0] mem [256];
      logic [DW-1:0] rd_reg;
      logic [DW-1:0] wr_data;

      if (gi == NLB - 1) begin : g_top
        assign wr_data = bus.in_data;
      end else begin : g_mid
        assign wr_data = lb_rd[gi + 1];
      end

      always_ff @(posedge clk) begin
        rd_reg <= mem[cnt_reg[7:0]];
        if (pend_reg && !rst) begin
          mem[cap_x_reg] <= wr_data;
        end
      end

      assign lb_rd[gi]               = rd_reg;
      assign new_data[gi*DW +: DW]   = rd_reg;
    end
  endgenerate

  assign new_data[NLB*DW +: DW] = bus.in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_x_reg      <= '0;
      out_y_reg      <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_x_reg     <= '0;
      skid_y_reg     <= '0;
    end else if (load_slot) begin
      if (skid_valid_reg) begin
        out_valid_reg  <= 1'b1;
        out_data_reg   <= skid_data_reg;
        out_x_reg      <= skid_x_reg;
        out_y_reg      <= skid_y_reg;
        skid_valid_reg <= col_new;
        if (col_new) begin
          skid_data_reg <= new_data;
          skid_x_reg    <= cap_x_reg;
          skid_y_reg    <= new_y;
        end
      end else if (col_new) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= new_data;
        out_x_reg     <= cap_x_reg;
        out_y_reg     <= new_y;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (col_new) begin
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= new_data;
      skid_x_reg     <= cap_x_reg;
      skid_y_reg     <= new_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (pend_reg && (cap_y_reg == 8'(K - 1)) && (cap_x_reg == 8'd0)) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (accept && last_col) begin
          state_next = DONE;
        end
      end
      default: state_next = DONE;
    endcase
  end

  assign bus.in_addr    = cnt_reg[15:0];
  assign bus.col_valid  = out_valid_reg;
  assign bus.col_data   = out_data_reg;
  assign bus.col_x      = out_x_reg;
  assign bus.col_y      = out_y_reg;
  assign bus.fetch_done = (state_reg == DONE);
endmodule

// File: tb/tb_bf_window_fetch.sv
// Self-checking bench for bf_window_fetch: a partial frame with random and held
// backpressure ending in a mid-frame reset, then a full frame with an in_valid gap.
module tb_bf_window_fetch;
  localparam int K    = 5;
  localparam int DW   = 8;
  localparam int HALF = (K - 1) / 2;
  localparam int NCOL = 256 * (256 - K + 1);
  localparam int LOW0 = 100 * 256 + 50;
  localparam int NT   = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bf_window_fetch_if #(.K(K), .DW(DW)) bus ();
  bf_window_fetch #(.K(K), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int pat      = 0;
  int sb_n     = 0;
  int sb_err   = 0;

  typedef struct {
    int            cyc;
    logic          exp_valid;
    int            exp_x;
    int            exp_y;
    logic          exp_done;
    int            exp_addr;
    logic          chk_data;
    logic [K*DW-1:0] exp_data;
  } vec_t;
  vec_t tbl [NT];

  function automatic logic [DW-1:0] pix(input int a);
    if (pat == 0) return DW'(a % 251);
    return DW'((a * 3 + 7) % 251);
  endfunction

  // Column n of a frame: x = n mod 256, centre row n/256 + HALF, oldest row first.
  function automatic logic [K*DW-1:0] exp_col(input int n);
    logic [K*DW-1:0] v;
    int x, yc;
    x  = n % 256;
    yc = n / 256 + HALF;
    for (int i = 0; i < K; i++) v[i*DW +: DW] = pix((yc - HALF + i) * 256 + x);
    return v;
  endfunction

  always @(posedge clk) bus.in_data <= pix(int'(bus.in_addr));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"},  64'(bus.in_addr),    64'd0);
    check({tag, "_valid"}, 64'(bus.col_valid),  64'd0);
    check({tag, "_data"},  64'(bus.col_data),   64'd0);
    check({tag, "_x"},     64'(bus.col_x),      64'd0);
    check({tag, "_y"},     64'(bus.col_y),      64'd0);
    check({tag, "_done"},  64'(bus.fetch_done), 64'd0);
  endtask

  task automatic cycle_begin();
    @(negedge clk);
  endtask

  task automatic cycle_end(input logic v, input logic r);
    bus.in_valid  = v;
    bus.col_ready = r;
    #1;
    if (!rst && bus.col_valid && bus.col_ready) begin
      if (sb_n >= NCOL) sb_err++;
      else if (bus.col_x != 8'(sb_n % 256) || bus.col_y != 8'(sb_n / 256 + HALF)
               || bus.col_data != exp_col(sb_n)) sb_err++;
      sb_n++;
    end
  endtask

  initial begin
    logic            found;
    logic [K*DW-1:0] snap_d;
    logic [7:0]      snap_x, snap_y;
    int              a0, frozen_err, tidx, first_cyc, done_cyc;

    tbl[0]  = '{0,     1'b0, 0,   0,   1'b0, 0,     1'b0, '0};
    tbl[1]  = '{1025,  1'b0, 0,   0,   1'b0, 1025,  1'b0, '0};
    tbl[2]  = '{1026,  1'b1, 0,   2,   1'b0, 1026,  1'b1, {8'd20, 8'd15, 8'd10, 8'd5, 8'd0}};
    tbl[3]  = '{1027,  1'b1, 1,   2,   1'b0, 1027,  1'b0, '0};
    tbl[4]  = '{1281,  1'b1, 255, 2,   1'b0, -1,    1'b0, '0};
    tbl[5]  = '{1282,  1'b1, 0,   3,   1'b0, -1,    1'b0, '0};
    tbl[6]  = '{25651, 1'b1, 49,  98,  1'b0, 25650, 1'b0, '0};
    tbl[7]  = '{25652, 1'b0, 0,   0,   1'b0, 25650, 1'b0, '0};
    tbl[8]  = '{25669, 1'b0, 0,   0,   1'b0, 25650, 1'b0, '0};
    tbl[9]  = '{25671, 1'b0, 0,   0,   1'b0, 25651, 1'b0, '0};
    tbl[10] = '{25672, 1'b1, 50,  98,  1'b0, 25652, 1'b0, '0};
    tbl[11] = '{65557, 1'b1, 255, 253, 1'b0, -1,    1'b0, '0};
    tbl[12] = '{65558, 1'b0, 0,   0,   1'b1, -1,    1'b0, '0};
    tbl[13] = '{65600, 1'b0, 0,   0,   1'b1, -1,    1'b0, '0};

    void'($urandom(32'd20240611));
    bus.in_valid  = 1'b0;
    bus.col_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;

    // Frame A: random ready over the first rows, held stall at (17,40), reset at row 50.
    pat = 1;
    sb_n = 0;
    sb_err = 0;
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      cycle_begin();
      if (bus.col_valid && bus.col_x == 8'd17 && bus.col_y == 8'd40) found = 1'b1;
      else cycle_end(1'b1, (sb_n < 768) ? 1'($urandom_range(0, 1)) : 1'b1);
    end
    check("bp_reach", 64'(found), 64'd1);
    if (found) begin
      snap_d = bus.col_data;
      snap_x = bus.col_x;
      snap_y = bus.col_y;
      a0 = int'(bus.in_addr);
      frozen_err = 0;
      for (int i = 0; i < 10; i++) begin
        if (i > 0) begin
          cycle_begin();
          if (!bus.col_valid || bus.col_data != snap_d || bus.col_x != snap_x
              || bus.col_y != snap_y) frozen_err++;
        end
        cycle_end(1'b1, 1'b0);
      end
      cycle_begin();
      check("bp_frozen", 64'(frozen_err), 64'd0);
      check("bp_addr_step", 64'((int'(bus.in_addr) - a0) <= 1), 64'd1);
      check("bp_resume_valid", 64'(bus.col_valid), 64'd1);
      check("bp_resume_x", 64'(bus.col_x), 64'd17);
      check("bp_resume_y", 64'(bus.col_y), 64'd40);
      cycle_end(1'b1, 1'b1);
      cycle_begin();
      check("bp_next_x", 64'(bus.col_x), 64'd18);
      check("bp_next_y", 64'(bus.col_y), 64'd40);
      cycle_end(1'b1, 1'b1);
    end

    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      cycle_begin();
      if (bus.col_valid && bus.col_y == 8'd50) found = 1'b1;
      else cycle_end(1'b1, 1'b1);
    end
    check("row50_reach", 64'(found), 64'd1);
    cycle_end(1'b1, 1'b0);
    cycle_begin();
    cycle_end(1'b1, 1'b0);
    cycle_begin();
    check("rst_pre_valid", 64'(bus.col_valid), 64'd1);
    rst = 1'b1;
    cycle_end(1'b1, 1'b1);
    cycle_begin();
    rst = 1'b0;
    check_reset("rst_mid");
    check("frameA_scoreboard", 64'(sb_err), 64'd0);
    check("frameA_progress", 64'(sb_n > 12000), 64'd1);
    cycle_end(1'b0, 1'b0);

    // Frame B: full frame, ready always high, in_valid low for 20 cycles in row 100.
    pat = 0;
    sb_n = 0;
    sb_err = 0;
    tidx = 0;
    first_cyc = -1;
    done_cyc = -1;
    for (int c = 0; c <= 65600; c++) begin
      cycle_begin();
      if (tidx < NT && tbl[tidx].cyc == c) begin
        check($sformatf("t%0d_valid", c), 64'(bus.col_valid), 64'(tbl[tidx].exp_valid));
        check($sformatf("t%0d_done", c), 64'(bus.fetch_done), 64'(tbl[tidx].exp_done));
        if (tbl[tidx].exp_addr >= 0)
          check($sformatf("t%0d_addr", c), 64'(bus.in_addr), 64'(tbl[tidx].exp_addr));
        if (tbl[tidx].exp_valid) begin
          check($sformatf("t%0d_x", c), 64'(bus.col_x), 64'(tbl[tidx].exp_x));
          check($sformatf("t%0d_y", c), 64'(bus.col_y), 64'(tbl[tidx].exp_y));
        end
        if (tbl[tidx].chk_data)
          check($sformatf("t%0d_data", c), 64'(bus.col_data), 64'(tbl[tidx].exp_data));
        tidx++;
      end
      if (first_cyc < 0 && bus.col_valid) first_cyc = c;
      if (done_cyc < 0 && bus.fetch_done) done_cyc = c;
      cycle_end(!(c >= LOW0 && c < LOW0 + 20), 1'b1);
    end
    check("frameB_table_used", 64'(tidx), 64'(NT));
    check("frameB_first_col_cycle", 64'(first_cyc), 64'd1026);
    check("frameB_done_cycle", 64'(done_cyc), 64'd65558);
    check("frameB_col_count", 64'(sb_n), 64'(NCOL));
    check("frameB_scoreboard", 64'(sb_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
